// File: rtl/activation_lut_fetcher.sv
// Fetches the two bracketing activation-table words for a signed sample x and
// presents {base, next_data, remaining} to a linear interpolator.
// Optional macro LUT_FETCH_CACHE_EN: reuse the last fetched pair when the index repeats.
module activation_lut_fetcher #(
  parameter int DATA_WIDTH = 8,
  parameter int INDEX_BITS = 4,
  parameter int FRAC_BITS  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_x,
  output logic                         rom_en,
  output logic [INDEX_BITS:0]          rom_addr,
  input  logic [DATA_WIDTH-1:0]        rom_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] base,
  output logic signed [DATA_WIDTH-1:0] next_data,
  output logic signed [DATA_WIDTH-1:0] remaining
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_BASE   = 3'd1,
    RD_NEXT   = 3'd2,
    WAIT_NEXT = 3'd3,
    OUT       = 3'd4
  } state_t;

  // Flipping the index MSB turns the two's-complement range into an unsigned table offset.
  localparam logic [INDEX_BITS-1:0] MSB_FLIP = INDEX_BITS'(1) << (INDEX_BITS - 1);

  state_t                  state_q, state_d;
  logic                    in_ready_q, in_ready_d;
  logic                    rom_en_q, rom_en_d;
  logic [INDEX_BITS:0]     rom_addr_q, rom_addr_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   base_q, base_d;
  logic [DATA_WIDTH-1:0]   next_q, next_d;
  logic [DATA_WIDTH-1:0]   rem_q, rem_d;
  logic [INDEX_BITS-1:0]   idx_q, idx_d;
  logic [INDEX_BITS-1:0]   idx_w;
  logic                    hit;

`ifdef LUT_FETCH_CACHE_EN
  logic [INDEX_BITS-1:0]   last_idx_q, last_idx_d;
  logic                    cache_vld_q, cache_vld_d;
`endif

  assign idx_w = in_x[DATA_WIDTH-1:FRAC_BITS] ^ MSB_FLIP;

`ifdef LUT_FETCH_CACHE_EN
  assign hit = cache_vld_q && (idx_w == last_idx_q);
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      rom_en_q    <= 1'b0;
      rom_addr_q  <= '0;
      out_valid_q <= 1'b0;
      base_q      <= '0;
      next_q      <= '0;
      rem_q       <= '0;
      idx_q       <= '0;
`ifdef LUT_FETCH_CACHE_EN
      last_idx_q  <= '0;
      cache_vld_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      rom_en_q    <= rom_en_d;
      rom_addr_q  <= rom_addr_d;
      out_valid_q <= out_valid_d;
      base_q      <= base_d;
      next_q      <= next_d;
      rem_q       <= rem_d;
      idx_q       <= idx_d;
`ifdef LUT_FETCH_CACHE_EN
      last_idx_q  <= last_idx_d;
      cache_vld_q <= cache_vld_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    rom_en_d    = rom_en_q;
    rom_addr_d  = rom_addr_q;
    out_valid_d = out_valid_q;
    base_d      = base_q;
    next_d      = next_q;
    rem_d       = rem_q;
    idx_d       = idx_q;
`ifdef LUT_FETCH_CACHE_EN
    last_idx_d  = last_idx_q;
    cache_vld_d = cache_vld_q;
`endif
    case (state_q)
      IDLE: begin
        // First edge out of reset only raises in_ready; samples are taken after that.
        if (!in_ready_q) begin
          in_ready_d = 1'b1;
        end else if (in_valid) begin
          in_ready_d = 1'b0;
          idx_d      = idx_w;
          rem_d      = {{(DATA_WIDTH-FRAC_BITS){1'b0}}, in_x[FRAC_BITS-1:0]};
          if (hit) begin
            state_d     = OUT;
            out_valid_d = 1'b1;
          end else begin
            state_d    = RD_BASE;
            rom_en_d   = 1'b1;
            rom_addr_d = {1'b0, idx_w};
          end
        end
      end
      RD_BASE: begin
        // Table has 2^INDEX_BITS+1 entries, so idx+1 never needs clamping.
        state_d    = RD_NEXT;
        rom_en_d   = 1'b1;
        rom_addr_d = {1'b0, idx_q} + (INDEX_BITS+1)'(1);
      end
      RD_NEXT: begin
        state_d  = WAIT_NEXT;
        base_d   = rom_data;
        rom_en_d = 1'b0;
      end
      WAIT_NEXT: begin
        state_d     = OUT;
        next_d      = rom_data;
        out_valid_d = 1'b1;
`ifdef LUT_FETCH_CACHE_EN
        last_idx_d  = idx_q;
        cache_vld_d = 1'b1;
`endif
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        rom_en_d    = 1'b0;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b0;
      end
    endcase
  end

  assign in_ready  = in_ready_q;
  assign rom_en    = rom_en_q;
  assign rom_addr  = rom_addr_q;
  assign out_valid = out_valid_q;
  assign base      = base_q;
  assign next_data = next_q;
  assign remaining = rem_q;

endmodule

// File: tb/tb_activation_lut_fetcher.sv
// Scoreboard bench for activation_lut_fetcher: driver pushes expectations from a
// table-level model, a negedge monitor pops and compares triples and ROM addresses.
module tb_activation_lut_fetcher;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_x;
  logic              rom_en;
  logic [4:0]        rom_addr;
  logic [7:0]        rom_data;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] base;
  logic signed [7:0] next_data;
  logic signed [7:0] remaining;

  activation_lut_fetcher #(.DATA_WIDTH(8), .INDEX_BITS(4), .FRAC_BITS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .base(base), .next_data(next_data), .remaining(remaining)
  );

  always #5 clk = ~clk;

  typedef struct {
    int b;
    int n;
    int r;
    int lat;
    int acc;
  } trip_t;

  trip_t exp_q[$];
  int    addr_q[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    bp_mode = 0;
  int    hold_cnt = 0;
  bit    seen = 0;
  bit    cache_v = 0;
  int    last_idx = 0;
  logic [7:0] tbl [0:16];

  initial for (int k = 0; k <= 16; k++) tbl[k] = 8'(8 * k - 64);

  // External ROM: one-cycle registered read
  always @(posedge clk) if (rom_en) rom_data <= tbl[rom_addr];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Downstream backpressure: 0 always ready, 1 random, 2 stall 4 cycles per triple
  always @(posedge clk) begin
    #2;
    if (!out_valid) hold_cnt = 0;
    else hold_cnt++;
    case (bp_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = (hold_cnt >= 4);
    endcase
  end

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (rom_en) begin
        if (addr_q.size() == 0) chk("rom_en_unexpected", 1, 0);
        else chk("rom_addr", int'(rom_addr), addr_q.pop_front());
      end
      if (out_valid) begin
        chk("in_ready_while_out", int'(in_ready), 0);
        if (exp_q.size() == 0) begin
          chk("out_valid_unexpected", 1, 0);
        end else begin
          if (!seen) begin
            seen = 1;
            chk("latency", cyc - exp_q[0].acc, exp_q[0].lat);
          end
          if (out_ready) begin
            chk("base", int'(base), exp_q[0].b);
            chk("next_data", int'(next_data), exp_q[0].n);
            chk("remaining", int'(remaining), exp_q[0].r);
            void'(exp_q.pop_front());
            seen = 0;
          end
        end
      end
    end
  end

  task automatic wait_ready();
    int guard = 0;
    while (in_ready !== 1'b1) begin
      in_valid = 1'b1;            // offered outside IDLE: must be ignored
      in_x = 8'($urandom);
      @(negedge clk);
      guard++;
      if (guard > 200) begin
        chk("in_ready_timeout", 0, 1);
        return;
      end
    end
  endtask

  task automatic send(input logic [7:0] x);
    int idx;
    bit hit;
    trip_t t;
    @(negedge clk);
    wait_ready();
    in_valid = 1'b1;
    in_x = x;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_x = 8'($urandom);
    idx = ($signed(x) + 128) / 16;
`ifdef LUT_FETCH_CACHE_EN
    hit = cache_v && (idx == last_idx);
`else
    hit = 0;
`endif
    t.b = 8 * idx - 64;
    t.n = 8 * (idx + 1) - 64;
    t.r = int'(x) % 16;
    t.lat = hit ? 0 : 3;
    t.acc = cyc;
    exp_q.push_back(t);
    if (!hit) begin
      addr_q.push_back(idx);
      addr_q.push_back(idx + 1);
    end
    cache_v = 1;
    last_idx = idx;
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 || in_ready !== 1'b1) begin
      @(negedge clk);
      guard++;
      if (guard > 500) begin
        chk("drain_timeout", exp_q.size(), 0);
        exp_q.delete();
        return;
      end
    end
  endtask

  task automatic rst_mid(input logic [7:0] x);
    @(negedge clk);
    wait_ready();
    in_valid = 1'b1;
    in_x = x;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    addr_q.push_back(($signed(x) + 128) / 16);
    @(posedge clk);               // now in RD_NEXT
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", int'(out_valid), 0);
    chk("rst_mid_rom_en", int'(rom_en), 0);
    chk("rst_mid_in_ready", int'(in_ready), 0);
    addr_q.delete();
    cache_v = 0;
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_release_in_ready", int'(in_ready), 1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_x = 8'h00;
    out_ready = 1'b1;
    #7;
    chk("reset_in_ready", int'(in_ready), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_rom_en", int'(rom_en), 0);
    chk("reset_rom_addr", int'(rom_addr), 0);
    chk("reset_base", int'(base), 0);
    chk("reset_next", int'(next_data), 0);
    chk("reset_remaining", int'(remaining), 0);
    #5 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("first_edge_in_ready", int'(in_ready), 1);

    send(8'h25);
    send(8'h80);
    send(8'h7F);
    drain();
    bp_mode = 2;
    send(8'hC3);
    drain();
    bp_mode = 0;
    send(8'h25);
    send(8'h2A);
    drain();
    rst_mid(8'h33);
    send(8'h33);
    drain();
    bp_mode = 1;
    for (int i = 0; i < 40; i++) begin
      send(8'($urandom));
      if (i == 20) bp_mode = 2;
      if (i == 25) bp_mode = 1;
    end
    drain();
    chk("addr_queue_empty", addr_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
